// File: rtl/cpu_icache_assoc.sv
// cpu_icache_assoc: two-way set-associative instruction cache, one 32-bit word per line, LRU replacement.
// Ports:
//   i_clock, i_reset            clock and synchronous active-high reset
//   i_input_tag / o_output_tag  request token in, completion token out (equal means idle)
//   i_address                   word-aligned fetch address, held while tags differ
//   o_rdata                     fetched instruction word
//   i_flush                     single-cycle pulse invalidating every line
//   o_bus_request, o_bus_address, i_bus_ready, i_bus_rdata  refill read port
//   o_hit_count, o_miss_count   free-running lookup statistics
module cpu_icache_assoc #(
    parameter int SIZE      = 8,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [TAG_WIDTH-1:0] i_input_tag,
    output logic [TAG_WIDTH-1:0] o_output_tag,
    input  logic [31:0]          i_address,
    output logic [31:0]          o_rdata,
    input  logic                 i_flush,
    output logic                 o_bus_request,
    input  logic                 i_bus_ready,
    output logic [31:0]          o_bus_address,
    input  logic [31:0]          i_bus_rdata,
    output logic [31:0]          o_hit_count,
    output logic [31:0]          o_miss_count
);
    localparam int SETS = 1 << SIZE;
    localparam int LW   = 30 - SIZE;

    typedef enum logic [1:0] {IDLE, LOOKUP, FILL, WRITE} state_t;

    state_t                 r_state;
    logic [TAG_WIDTH-1:0]   r_output_tag;
    logic [31:0]            r_rdata;
    logic                   r_bus_request;
    logic [31:0]            r_bus_address;
    logic [31:0]            r_hit_count;
    logic [31:0]            r_miss_count;
    logic [SETS-1:0]        r_valid0;
    logic [SETS-1:0]        r_valid1;
    logic [SETS-1:0]        r_lru;
    logic                   r_victim;
    logic                   r_fill_flushed;
    logic [LW-1:0]          r_tag0  [SETS];
    logic [LW-1:0]          r_tag1  [SETS];
    logic [31:0]            r_data0 [SETS];
    logic [31:0]            r_data1 [SETS];
    logic [LW-1:0]          r_rd_tag0;
    logic [LW-1:0]          r_rd_tag1;
    logic [31:0]            r_rd_data0;
    logic [31:0]            r_rd_data1;

    logic [SIZE-1:0]        w_index;
    logic [LW-1:0]          w_tag;
    logic [SIZE-1:0]        w_wr_index;
    logic [LW-1:0]          w_wr_tag;
    logic                   w_hit0;
    logic                   w_hit1;
    logic                   w_unused;

    assign w_index    = i_address[SIZE+1:2];
    assign w_tag      = i_address[31:SIZE+2];
    // The requester may move on once the token completes, so the line being
    // committed is addressed from the captured refill address.
    assign w_wr_index = r_bus_address[SIZE+1:2];
    assign w_wr_tag   = r_bus_address[31:SIZE+2];
    assign w_hit0     = r_valid0[w_index] && (r_rd_tag0 == w_tag);
    assign w_hit1     = r_valid1[w_index] && (r_rd_tag1 == w_tag);
    assign w_unused   = ^i_address[1:0];

    assign o_output_tag  = r_output_tag;
    assign o_rdata       = r_rdata;
    assign o_bus_request = r_bus_request;
    assign o_bus_address = r_bus_address;
    assign o_hit_count   = r_hit_count;
    assign o_miss_count  = r_miss_count;

    // Storage is not reset; the valid bits alone decide whether a line can hit.
    // Reads are registered every cycle so LOOKUP sees the set captured on entry.
    always_ff @(posedge i_clock) begin
        r_rd_tag0  <= r_tag0[w_index];
        r_rd_tag1  <= r_tag1[w_index];
        r_rd_data0 <= r_data0[w_index];
        r_rd_data1 <= r_data1[w_index];
        if (!i_reset && r_state == WRITE) begin
            if (r_victim) begin
                r_tag1[w_wr_index]  <= w_wr_tag;
                r_data1[w_wr_index] <= r_rdata;
            end else begin
                r_tag0[w_wr_index]  <= w_wr_tag;
                r_data0[w_wr_index] <= r_rdata;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state        <= IDLE;
            r_output_tag   <= '0;
            r_rdata        <= '0;
            r_bus_request  <= 1'b0;
            r_bus_address  <= '0;
            r_hit_count    <= '0;
            r_miss_count   <= '0;
            r_valid0       <= '0;
            r_valid1       <= '0;
            r_lru          <= '0;
            r_victim       <= 1'b0;
            r_fill_flushed <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (i_input_tag != r_output_tag) r_state <= LOOKUP;
                LOOKUP: begin
                    if (w_hit0 || w_hit1) begin
                        r_rdata          <= w_hit0 ? r_rd_data0 : r_rd_data1;
                        r_output_tag     <= i_input_tag;
                        r_lru[w_index]   <= w_hit0;
                        r_hit_count      <= r_hit_count + 32'd1;
                        r_state          <= IDLE;
                    end else begin
                        r_miss_count   <= r_miss_count + 32'd1;
                        r_bus_request  <= 1'b1;
                        r_bus_address  <= i_address;
                        r_victim       <= !r_valid0[w_index] ? 1'b0 : !r_valid1[w_index] ? 1'b1 : r_lru[w_index];
                        r_fill_flushed <= i_flush;
                        r_state        <= FILL;
                    end
                end
                FILL: begin
                    // A flush anywhere in the refill keeps the word for the
                    // requester but must stop the line becoming valid.
                    r_fill_flushed <= r_fill_flushed | i_flush;
                    if (i_bus_ready) begin
                        r_bus_request <= 1'b0;
                        r_rdata       <= i_bus_rdata;
                        r_output_tag  <= i_input_tag;
                        r_state       <= WRITE;
                    end
                end
                WRITE: begin
                    r_lru[w_wr_index] <= ~r_victim;
                    if (!r_fill_flushed) begin
                        if (r_victim) r_valid1[w_wr_index] <= 1'b1;
                        else r_valid0[w_wr_index] <= 1'b1;
                    end
                    r_state <= IDLE;
                end
            endcase
            // Last assignment wins, so a flush beats the valid set in WRITE.
            if (i_flush) begin
                r_valid0 <= '0;
                r_valid1 <= '0;
            end
        end
    end
endmodule
